glide_sequencer: RTL and testbench

Command-driven target generator for the APU slew limiter (lerper). It accepts timed glide commands (target value, signed speed, hold duration) through a valid/ready handshake into a small FIFO. It drives each command's target and speed onto the lerper's `i_signal`/`speed` inputs, then holds it for the commanded number of sample ticks. Sits between the APU register/command front end and the lerper, producing portamento and pitch/volume envelopes without CPU timing.

---
 rtl/glide_sequencer.sv | 174 +++++++++++++++++
 tb/tb_glide_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/glide_sequencer.sv
// Timed glide command FIFO + sequencer feeding the lerper's target/speed inputs.
// Optional internal tick prescaler enabled by defining GLIDE_SEQ_TICKDIV_EN.
module glide_sequencer #(
  parameter int unsigned SIGNAL_WIDTH = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DUR_WIDTH    = 16,
  parameter int unsigned TICK_DIV     = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [SIGNAL_WIDTH-1:0]    i_target,
  input  logic [15:0]                i_speed,
  input  logic [DUR_WIDTH-1:0]       i_duration,
  input  logic                       i_tick,
  input  logic                       i_flush,
  output logic [SIGNAL_WIDTH-1:0]    o_signal,
  output logic [15:0]                o_speed,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_underrun
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD
  } state_e;

  state_e state_q;

  logic [SIGNAL_WIDTH-1:0] tgt_mem_q [DEPTH];
  logic [15:0]             spd_mem_q [DEPTH];
  logic [DUR_WIDTH-1:0]    dur_mem_q [DEPTH];

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [SIGNAL_WIDTH-1:0] signal_q;
  logic [15:0]             speed_q;
  logic [DUR_WIDTH-1:0]    cnt_q;
  logic                    underrun_q;

  logic push;
  logic pop;
  logic tick;

`ifdef GLIDE_SEQ_TICKDIV_EN
  localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PSW-1:0] presc_q, presc_d;
  logic           unused_tick;

  assign unused_tick = i_tick;
  assign tick        = (presc_q == PSW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PSW'(1);
    if (i_flush || tick) presc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TICK_DIV != 0);
  assign tick       = i_tick;
`endif

  assign o_ready    = (level_q != LW'(DEPTH));
  assign o_level    = level_q;
  assign o_signal   = signal_q;
  assign o_speed    = speed_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_underrun = underrun_q;

  // Flush suppresses both handshakes so it cleanly dominates any same-cycle push/pop.
  assign push = i_valid && o_ready && !i_flush;
  assign pop  = (state_q == S_LOAD) && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tgt_mem_q[wr_ptr_q] <= i_target;
      spd_mem_q[wr_ptr_q] <= i_speed;
      dur_mem_q[wr_ptr_q] <= i_duration;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      signal_q   <= '0;
      speed_q    <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (i_flush) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (level_q != '0) state_q <= S_LOAD;
          end
          S_LOAD: begin
            signal_q <= tgt_mem_q[rd_ptr_q];
            speed_q  <= spd_mem_q[rd_ptr_q];
            cnt_q    <= dur_mem_q[rd_ptr_q];
            // Zero-length commands chain straight on if anything remains behind the popped head.
            if (dur_mem_q[rd_ptr_q] != '0)  state_q <= S_HOLD;
            else if (level_q > LW'(1))      state_q <= S_LOAD;
            else                            state_q <= S_IDLE;
          end
          S_HOLD: begin
            if (tick) begin
              if (cnt_q == DUR_WIDTH'(1)) begin
                cnt_q <= '0;
                if (level_q != '0) begin
                  state_q <= S_LOAD;
                end else begin
                  state_q    <= S_IDLE;
                  underrun_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q - DUR_WIDTH'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glide_sequencer.sv
// Directed self-checking bench for glide_sequencer (default build, external ticks).
module tb_glide_sequencer;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_target;
  logic [15:0] i_speed;
  logic [15:0] i_duration;
  logic        i_tick;
  logic        i_flush;
  logic [15:0] o_signal;
  logic [15:0] o_speed;
  logic        o_busy;
  logic [2:0]  o_level;
  logic        o_underrun;

  int checks;
  int failures;

  glide_sequencer #(
    .SIGNAL_WIDTH(16),
    .DEPTH(4),
    .DUR_WIDTH(16),
    .TICK_DIV(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_target(i_target),
    .i_speed(i_speed),
    .i_duration(i_duration),
    .i_tick(i_tick),
    .i_flush(i_flush),
    .o_signal(o_signal),
    .o_speed(o_speed),
    .o_busy(o_busy),
    .o_level(o_level),
    .o_underrun(o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge; inputs and samples live 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [15:0] t, input logic [15:0] s, input logic [15:0] d);
    i_valid    = 1'b1;
    i_target   = t;
    i_speed    = s;
    i_duration = d;
  endtask

  task automatic tick_step();
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_target   = '0;
    i_speed    = '0;
    i_duration = '0;
    i_tick     = 1'b0;
    i_flush    = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_signal",   o_signal,   0);
    check("rst_speed",    o_speed,    0);
    check("rst_ready",    o_ready,    1);
    check("rst_busy",     o_busy,     0);
    check("rst_level",    o_level,    0);
    check("rst_underrun", o_underrun, 0);

    // Single command {0x1000, 4, 3}
    set_cmd(16'h1000, 16'd4, 16'd3);
    step();
    i_valid = 1'b0;
    check("s1_level_after_push", o_level, 1);
    check("s1_busy_after_push",  o_busy,  0);
    step();
    check("s1_busy_load",   o_busy,   1);
    check("s1_signal_load", o_signal, 0);
    step();
    check("s1_signal", o_signal, 16'h1000);
    check("s1_speed",  o_speed,  4);
    check("s1_level",  o_level,  0);
    tick_step();
    step();
    tick_step();
    check("s1_busy_t2",     o_busy,     1);
    check("s1_underrun_t2", o_underrun, 0);
    check("s1_signal_t2",   o_signal,   16'h1000);
    tick_step();
    check("s1_underrun", o_underrun, 1);
    check("s1_idle",     o_busy,     0);
    step();
    check("s1_underrun_clr", o_underrun, 0);
    check("s1_signal_kept",  o_signal,   16'h1000);

    // Fill: A loads and holds, B..E fill FIFO, F is refused
    set_cmd(16'hAAAA, 16'd1, 16'd1);
    step();
    set_cmd(16'h0B0B, 16'hFFFF, 16'd5);
    step();
    set_cmd(16'h0C0C, 16'd2, 16'd5);
    step();
    check("fill_signal_a", o_signal, 16'hAAAA);
    set_cmd(16'h0D0D, 16'd3, 16'd5);
    step();
    set_cmd(16'h0E0E, 16'd4, 16'd5);
    step();
    check("fill_level4", o_level, 4);
    check("fill_ready0", o_ready, 0);
    set_cmd(16'h0F0F, 16'd5, 16'd5);
    step();
    check("fill_refused_level", o_level, 4);
    tick_step();
    check("fill_no_underrun", o_underrun, 0);
    check("fill_level_still4", o_level, 4);
    step();
    check("fill_pop_refused_level", o_level, 3);
    check("fill_signal_b", o_signal, 16'h0B0B);
    check("fill_speed_b",  o_speed,  16'hFFFF);
    check("fill_ready1",   o_ready,  1);
    i_valid = 1'b0;

    // Flush with 3 queued entries and a simultaneous push
    set_cmd(16'h0F0F, 16'd5, 16'd5);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_level",  o_level,  0);
    check("flush_busy",   o_busy,   0);
    check("flush_signal", o_signal, 16'h0B0B);
    check("flush_speed",  o_speed,  16'hFFFF);
    step();
    step();
    check("flush_push_dropped", o_level, 0);
    check("flush_stays_idle",   o_busy,  0);
    check("flush_signal_kept",  o_signal, 16'h0B0B);

    // Chain {0x0100,-4,2}, {0x0200,0,0}, {0x0300,2,1}
    set_cmd(16'h0100, 16'hFFFC, 16'd2);
    step();
    set_cmd(16'h0200, 16'd0, 16'd0);
    step();
    set_cmd(16'h0300, 16'd2, 16'd1);
    step();
    i_valid = 1'b0;
    check("ch_sig1",   o_signal, 16'h0100);
    check("ch_spd1",   o_speed,  16'hFFFC);
    check("ch_level2", o_level,  2);
    tick_step();
    tick_step();
    check("ch_no_ur1",   o_underrun, 0);
    check("ch_sig1_end", o_signal,   16'h0100);
    step();
    check("ch_sig2", o_signal, 16'h0200);
    check("ch_spd2", o_speed,  0);
    step();
    check("ch_sig3",    o_signal,   16'h0300);
    check("ch_spd3",    o_speed,    2);
    check("ch_no_ur2",  o_underrun, 0);
    check("ch_level0",  o_level,    0);
    step();
    check("ch_hold3_busy", o_busy, 1);
    tick_step();
    check("ch_final_ur", o_underrun, 1);
    check("ch_idle",     o_busy,     0);
    step();
    check("ch_ur_clr", o_underrun, 0);

    // Asynchronous reset mid-HOLD
    set_cmd(16'h1234, 16'd7, 16'd9);
    step();
    i_valid = 1'b0;
    step();
    step();
    check("ar_signal_before", o_signal, 16'h1234);
    check("ar_busy_before",   o_busy,   1);
    #2 rst = 1'b1;
    #1;
    check("ar_signal",   o_signal,   0);
    check("ar_speed",    o_speed,    0);
    check("ar_ready",    o_ready,    1);
    check("ar_busy",     o_busy,     0);
    check("ar_level",    o_level,    0);
    check("ar_underrun", o_underrun, 0);
    step();
    rst = 1'b0;
    step();
    check("ar_idle_after", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
